// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, width helper and default operand width.
package alu_pkg;

    localparam int BITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Ceiling log2, same rounding as the multiplier helper ($clog2-equivalent).
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import alu_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic [BITS-1:0] rem_in,
    input  logic            next_bit,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] rem_out,
    output logic            q_bit
);

    logic [BITS:0] trial;
    logic [BITS:0] diff;

    // rem_in < divisor always holds, so the top bit of diff is a reliable sign of the trial subtraction.
    always_comb begin
        trial   = {rem_in, next_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[BITS];
        rem_out = q_bit ? diff[BITS-1:0] : trial[BITS-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider with sign-magnitude interface and start/done handshake.
module divider_seq
    import alu_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            Sign_a,
    input  logic            Sign_b,
    output logic [BITS-1:0] Q,
    output logic [BITS-1:0] R,
    output logic            Turn,
    output logic            R_sign,
    output logic            Div_zero,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W = (log2(BITS) < 1) ? 1 : log2(BITS);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [BITS-1:0] divisor_q, divisor_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] quot_q, quot_d;
    logic [BITS-1:0] remout_q, remout_d;
    logic            turn_q, turn_d;
    logic            r_sign_q, r_sign_d;
    logic            div_zero_q, div_zero_d;

    logic [BITS-1:0] step_rem;
    logic            step_bit;

    div_step #(.BITS(BITS)) u_step (
        .rem_in   (rem_q),
        .next_bit (shift_q[BITS-1]),
        .divisor  (divisor_q),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        remout_d   = remout_q;
        turn_d     = turn_q;
        r_sign_d   = r_sign_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    turn_d   = Sign_a ^ Sign_b;
                    r_sign_d = Sign_a;
                    if (B == '0) begin
                        quot_d     = '1;
                        remout_d   = A;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        shift_d    = A;
                        divisor_d  = B;
                        rem_d      = '0;
                        count_d    = CNT_W'(BITS - 1);
                        div_zero_d = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                shift_d = {shift_q[BITS-2:0], step_bit};
                rem_d   = step_rem;
                if (count_q == '0) begin
                    quot_d   = {shift_q[BITS-2:0], step_bit};
                    remout_d = step_rem;
                    state_d  = DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            remout_q   <= '0;
            turn_q     <= 1'b0;
            r_sign_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            remout_q   <= remout_d;
            turn_q     <= turn_d;
            r_sign_q   <= r_sign_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Q        = quot_q;
    assign R        = remout_q;
    assign Turn     = turn_q;
    assign R_sign   = r_sign_q;
    assign Div_zero = div_zero_q;
    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq (BITS=16) with hand-computed expected results.
module tb_divider_seq;

    localparam int BITS = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic            Sign_a;
    logic            Sign_b;
    logic [BITS-1:0] Q;
    logic [BITS-1:0] R;
    logic            Turn;
    logic            R_sign;
    logic            Div_zero;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cycles;
    int busy_cycles;

    divider_seq #(.BITS(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Sign_a   (Sign_a),
        .Sign_b   (Sign_b),
        .Q        (Q),
        .R        (R),
        .Turn     (Turn),
        .R_sign   (R_sign),
        .Div_zero (Div_zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives operands with a one-cycle start pulse; returns 1 time unit after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                 input logic sa, input logic sb);
        @(negedge clk);
        A      = a;
        B      = b;
        Sign_a = sa;
        Sign_b = sb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Steps until done is seen or the budget runs out; counts cycles spent with busy high.
    task automatic wait_done(input int first_cycle, output int cyc, output int busy_seen);
        cyc       = first_cycle;
        busy_seen = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_seen++;
            step_cycle();
            cyc++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        Sign_a = 1'b0;
        Sign_b = 1'b0;
        repeat (2) step_cycle();

        checkOutput("reset_Q", 32'(Q), 32'h0);
        checkOutput("reset_R", 32'(R), 32'h0);
        checkOutput("reset_flags", {27'h0, Turn, R_sign, Div_zero, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 100 / 7
        applyStimulus(16'd100, 16'd7, 1'b0, 1'b0);
        checkOutput("basic_busy_c1", 32'(busy), 32'h1);
        wait_done(1, cycles, busy_cycles);
        checkOutput("basic_latency", 32'(cycles), 32'd17);
        checkOutput("basic_busy_cycles", 32'(busy_cycles), 32'd16);
        checkOutput("basic_Q", 32'(Q), 32'd14);
        checkOutput("basic_R", 32'(R), 32'd2);
        checkOutput("basic_flags", {28'h0, Turn, R_sign, Div_zero, busy}, 32'h0);
        step_cycle();
        checkOutput("basic_done_pulse", 32'(done), 32'h0);
        checkOutput("basic_Q_held", 32'(Q), 32'd14);

        // 0xFFFF / 1 then back-to-back 3 / 10 issued in the DONE cycle
        applyStimulus(16'hFFFF, 16'd1, 1'b0, 1'b0);
        wait_done(1, cycles, busy_cycles);
        checkOutput("max_latency", 32'(cycles), 32'd17);
        checkOutput("max_Q", 32'(Q), 32'hFFFF);
        checkOutput("max_R", 32'(R), 32'h0);
        applyStimulus(16'd3, 16'd10, 1'b0, 1'b0);
        checkOutput("b2b_busy", 32'(busy), 32'h1);
        wait_done(1, cycles, busy_cycles);
        checkOutput("b2b_latency", 32'(cycles), 32'd17);
        checkOutput("b2b_Q", 32'(Q), 32'h0);
        checkOutput("b2b_R", 32'(R), 32'd3);

        // divide by zero
        step_cycle();
        applyStimulus(16'd5, 16'd0, 1'b1, 1'b0);
        wait_done(1, cycles, busy_cycles);
        checkOutput("dz_latency", 32'(cycles), 32'd1);
        checkOutput("dz_Q", 32'(Q), 32'hFFFF);
        checkOutput("dz_R", 32'(R), 32'd5);
        checkOutput("dz_flags", {28'h0, Div_zero, R_sign, Turn, busy}, 32'b1110);

        // signed operands: only the raw sign flags change
        step_cycle();
        applyStimulus(16'd9, 16'd2, 1'b1, 1'b0);
        wait_done(1, cycles, busy_cycles);
        checkOutput("sign10_Q", 32'(Q), 32'd4);
        checkOutput("sign10_R", 32'(R), 32'd1);
        checkOutput("sign10_flags", {29'h0, Turn, R_sign, Div_zero}, 32'b110);
        step_cycle();
        applyStimulus(16'd9, 16'd2, 1'b1, 1'b1);
        wait_done(1, cycles, busy_cycles);
        checkOutput("sign11_Q", 32'(Q), 32'd4);
        checkOutput("sign11_flags", {29'h0, Turn, R_sign, Div_zero}, 32'b010);

        // start with new operands during CALC is ignored
        step_cycle();
        applyStimulus(16'd100, 16'd7, 1'b0, 1'b0);
        repeat (4) step_cycle();
        @(negedge clk);
        A      = 16'd200;
        B      = 16'd3;
        Sign_a = 1'b1;
        start  = 1'b1;
        step_cycle();
        start = 1'b0;
        wait_done(6, cycles, busy_cycles);
        checkOutput("ignore_latency", 32'(cycles), 32'd17);
        checkOutput("ignore_Q", 32'(Q), 32'd14);
        checkOutput("ignore_R", 32'(R), 32'd2);
        checkOutput("ignore_flags", {30'h0, Turn, R_sign}, 32'h0);

        // reset at CALC cycle 8 aborts the operation
        step_cycle();
        applyStimulus(16'd100, 16'd7, 1'b1, 1'b0);
        repeat (7) step_cycle();
        checkOutput("abort_busy_c8", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        step_cycle();
        checkOutput("abort_Q", 32'(Q), 32'h0);
        checkOutput("abort_R", 32'(R), 32'h0);
        checkOutput("abort_flags", {27'h0, Turn, R_sign, Div_zero, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            if (done || busy) busy_cycles++;
        end
        checkOutput("abort_no_done", 32'(busy_cycles), 32'h0);
        applyStimulus(16'd100, 16'd7, 1'b0, 1'b0);
        wait_done(1, cycles, busy_cycles);
        checkOutput("fresh_latency", 32'(cycles), 32'd17);
        checkOutput("fresh_Q", 32'(Q), 32'd14);
        checkOutput("fresh_R", 32'(R), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Sequential radix-2 restoring divider for the ALU. It is the inverse operation of the combinational sign-magnitude multiplier and uses the same magnitude and sign interface (A, B, Sign_a, Sign_b, Turn).
- Accepts unsigned magnitudes plus separate sign bits.
- Produces one quotient bit per clock.
- Returns quotient, remainder and sign flags with a start/done handshake.
- Sits beside the multiplier in the ALU execute stage, which stalls on busy.

Parameters:
BITS, 16, operand/result width in bits (>=2).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE or DONE
A  in  BITS  dividend magnitude
B  in  BITS  divisor magnitude
Sign_a  in  1  dividend sign
Sign_b  in  1  divisor sign
Q  out  BITS  quotient magnitude
R  out  BITS  remainder magnitude
Turn  out  1  quotient sign = Sign_a^Sign_b, latched at start
R_sign  out  1  remainder sign = Sign_a, latched at start
Div_zero  out  1  divisor was zero
busy  out  1  calculation in progress
done  out  1  one-cycle pulse, results valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; Q, R, Turn, R_sign, Div_zero, busy, done, internal counter and dividend shift register all 0.
- Reset mid-operation aborts immediately. No done is produced, and outputs return to reset values on the next edge.
- States: IDLE, CALC, DONE.
- IDLE + start, B!=0:
  - latch A into the shift register and B into the divisor register;
  - clear the partial remainder;
  - set count=BITS-1;
  - latch Turn and R_sign; clear Div_zero;
  - go to CALC.
- IDLE + start, B==0:
  - Q = all ones, R = A, Div_zero = 1;
  - latch Turn and R_sign;
  - go to DONE. done is asserted the cycle after start.
- CALC, one step per cycle:
  - trial = {rem[BITS-1:0], msb of shift register}, width BITS+1;
  - diff = trial - {1'b0, divisor};
  - if diff is non-negative: rem = diff and quotient bit = 1; otherwise rem = trial[BITS-1:0] and quotient bit = 0;
  - the quotient bit shifts into the LSB of the shift register, which becomes Q.
- CALC exit: when count==0, go to DONE and update Q/R; otherwise decrement count.
- The partial remainder is BITS+1 wide internally so no overflow is possible. Q and R are truncation-free.
- Latency: BITS cycles in CALC, so done is high exactly BITS+1 cycles after the start edge (17 for BITS=16).
- DONE: done=1 and busy=0 for one cycle. Q, R and flags are valid from DONE onward and held stable until the next accepted start.
- DONE + start: a new operation is accepted (back-to-back), with the same load rules as IDLE. Otherwise go to IDLE.
- busy=1 only in CALC. start during CALC is ignored, and A/B changes during CALC are ignored.
- Sign handling:
  - Turn and R_sign are reported raw, with no zero-result normalisation;
  - the consumer applies signs;
  - on Div_zero, Turn and R_sign are still latched.

Decomposition:
- Shared package alu_pkg:
  - typedef enum of div states {IDLE, CALC, DONE};
  - log2 function used for the counter width, $clog2-equivalent to the multiplier helper;
  - BITS default constant.
- One natural sub-module: div_step. It is a combinational single restoring step that takes rem, next bit and divisor, and returns the new rem and the quotient bit. The top instantiates it once and iterates it over time.

Test Plan:
- A=100, B=7, signs 0 -> done at cycle 17; Q=14, R=2, Turn=0, R_sign=0, Div_zero=0; busy high for cycles 1..16.
- A=0xFFFF, B=1 -> Q=0xFFFF, R=0. Then A=3, B=10 issued in the DONE cycle (back-to-back) -> Q=0, R=3 seventeen cycles later.
- A=5, B=0, Sign_a=1 -> done 1 cycle after start; Div_zero=1, Q=0xFFFF, R=5, R_sign=1, Turn=Sign_b^1.
- Sign_a=1, Sign_b=0, A=9, B=2 -> Q=4, R=1, Turn=1, R_sign=1. Then Sign_a=1, Sign_b=1 -> Turn=0.
- start plus changed A/B pulsed at cycle 5 of CALC -> ignored; original result unchanged and done only at cycle 17.
- rst asserted at CALC cycle 8 -> next edge: IDLE, all outputs 0, no done pulse. A fresh start afterwards computes 100/7 correctly.
